fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the 16-bit pipelined core; directly feeds the IF/ID pipeline register.
- Owns the PC and drives the instruction-memory request/ready handshake. Memory latency is variable: same-cycle hit or multi-cycle.
- Absorbs decode-side stalls with a one-entry buffer, accepts branch/jump redirects, and stops fetching on HALT.
- Emits NOP bubbles, flagged on stall_out, whenever it has no valid instruction.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- NOP_INST, 16'h0800, instruction word driven on inst_out during a bubble.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- stall_in  in  1  hazard unit holds IF/ID; the delivered instruction is not consumed this cycle.
- redirect_valid  in  1  taken branch/jump from a later stage; squashes fetch.
- redirect_pc  in  16  target PC, valid with redirect_valid.
- imem_req  out  1  instruction-memory request.
- imem_addr  out  16  request address.
- imem_ready  in  1  one-cycle pulse; imem_rdata valid in that cycle.
- imem_rdata  in  16  instruction word.
- inst_out  out  16  instruction to IF/ID (inst_in).
- pc_out_out  out  16  PC of inst_out.
- pc_inc_out  out  16  pc_out_out + 2.
- stall_out  out  1  1 = bubble (inst_out = NOP_INST).
- halt_out  out  1  registered; 1 once HALT is consumed.

Behaviour:
- Registers:
  - pc (16): address of the next instruction to deliver.
  - drain_addr (16).
  - buf_inst (16) and buf_valid.
  - state: FETCH / DRAIN / HALTED.
  - halt_out.
- Async reset:
  - pc = RESET_PC, state = FETCH, buf_valid = 0, drain_addr = 0, halt_out = 0.
  - While rst is high: imem_req = 0, stall_out = 1, inst_out = NOP_INST, pc_out_out = RESET_PC, pc_inc_out = RESET_PC + 2.
  - Reset mid-transaction abandons it; the memory model must tolerate a dropped request.
- Request generation:
  - imem_req = (state == FETCH and !buf_valid) or state == DRAIN.
  - imem_addr = drain_addr in DRAIN, else pc.
  - Address is stable while imem_req is high and imem_ready is low.
- "avail" means buf_valid, or (state == FETCH and imem_req and imem_ready).
- Output rule (combinational):
  - If avail and !redirect_valid: inst_out = buf_valid ? buf_inst : imem_rdata, stall_out = 0, pc_out_out = pc, pc_inc_out = pc + 2 (mod 2^16, 16'hFFFE+2 = 16'h0000).
  - Otherwise: inst_out = NOP_INST, stall_out = 1, pc_out_out = pc.
  - Zero extra latency: a same-cycle hit reaches inst_out in the request cycle.
- Consume = avail and !stall_in and !redirect_valid.
  - pc <= pc + 2 and buf_valid <= 0.
  - If inst_out[15:11] == 5'b00000 (HALT): state <= HALTED, pc unchanged, halt_out <= 1.
- Stall capture: avail from memory with stall_in = 1 and no redirect → buf_inst <= imem_rdata, buf_valid <= 1. No new request until the buffer is consumed. A buffered instruction is re-presented every cycle until consumed.
- Redirect (highest priority, any state):
  - Always: pc <= redirect_pc, buf_valid <= 0, halt_out <= 0; the cycle's output is a bubble.
  - FETCH with imem_req = 1 and imem_ready = 0: drain_addr <= pc, state <= DRAIN.
  - Otherwise: state <= FETCH.
  - Redirect while in DRAIN: update pc only; stay DRAIN.
- DRAIN:
  - Holds the old request until imem_ready, discards the data, then state <= FETCH.
  - A new request to pc issues the next cycle.
  - stall_in has no effect in DRAIN.
- HALTED:
  - imem_req = 0, stall_out = 1.
  - Leaves only on redirect (an older mispredicted branch) or reset.
- stall_in with no avail: no effect beyond normal waiting.

Test Plan:
- Reset then 0-latency memory (ready tied = req) holding 16'h4000, 16'h4001, 16'h4002 at 0/2/4 → inst_out sequence 4000/4001/4002 on consecutive cycles, pc_out_out 0/2/4, pc_inc_out 2/4/6, stall_out 0.
- 3-cycle memory latency → stall_out = 1 for 2 cycles and 0 for 1 cycle per instruction; imem_addr is constant while waiting.
- Hit arrives with stall_in = 1 for 3 cycles → imem_req = 0 after capture; the same inst/pc is presented 3 cycles; consumed on the 4th; pc advances by exactly 2.
- Redirect to 16'h0100 during an outstanding 3-cycle fetch of 16'h0008:
  - Enters DRAIN with imem_addr held at 16'h0008 until ready.
  - The returned word is discarded (stall_out = 1).
  - Next request is at 16'h0100.
- Fetch HALT (16'h0000) at 16'h0006 → after consumption: halt_out = 1, imem_req = 0, pc = 16'h0006; a later redirect to 16'h0020 clears halt_out and resumes fetching at 16'h0020.
- Two edge cases:
  - pc = 16'hFFFE consumed → pc wraps to 16'h0000.
  - rst asserted mid-wait → imem_req drops immediately (asynchronously) and pc = RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC and runs the imem req/ready handshake.
// Adds a one-entry stall buffer, redirect draining and HALT detection.
module fetch_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP_INST = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_in,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ready,
    input  logic [15:0] imem_rdata,
    output logic [15:0] inst_out,
    output logic [15:0] pc_out_out,
    output logic [15:0] pc_inc_out,
    output logic        stall_out,
    output logic        halt_out
);

    // state     | meaning
    // ST_FETCH  | normal fetch from r_pc (or present the buffered word)
    // ST_DRAIN  | wait out a request squashed by a redirect, discard its data
    // ST_HALTED | HALT consumed; no requests until redirect or reset
    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t      r_state;
    logic [15:0] r_pc;
    logic [15:0] r_drain_addr;
    logic [15:0] r_buf_inst;
    logic        r_buf_valid;
    logic        r_halt;

    state_t      w_state_nxt;
    logic [15:0] w_pc_nxt;
    logic [15:0] w_drain_addr_nxt;
    logic [15:0] w_buf_inst_nxt;
    logic        w_buf_valid_nxt;
    logic        w_halt_nxt;

    logic        w_req;
    logic        w_avail;
    logic        w_present;
    logic        w_consume;
    logic        w_is_halt;
    logic [15:0] w_inst;
    logic [15:0] w_pc_inc;

    // Outputs are forced to the reset view while rst is high, not one cycle later.
    always_comb begin
        w_req   = 1'b0;
        w_avail = 1'b0;
        if (!rst) begin
            w_req   = ((r_state == ST_FETCH) && !r_buf_valid) || (r_state == ST_DRAIN);
            w_avail = r_buf_valid || ((r_state == ST_FETCH) && w_req && imem_ready);
        end
        w_present = w_avail && !redirect_valid;
        w_consume = w_present && !stall_in;
    end

    assign w_inst    = w_present ? (r_buf_valid ? r_buf_inst : imem_rdata) : NOP_INST;
    assign w_is_halt = (w_inst[15:11] == 5'b00000);
    assign w_pc_inc  = r_pc + 16'd2;

    assign imem_req   = w_req;
    assign imem_addr  = (r_state == ST_DRAIN) ? r_drain_addr : r_pc;
    assign inst_out   = w_inst;
    assign stall_out  = !w_present;
    assign pc_out_out = r_pc;
    assign pc_inc_out = w_pc_inc;
    assign halt_out   = r_halt;

    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_drain_addr_nxt = r_drain_addr;
        w_buf_inst_nxt   = r_buf_inst;
        w_buf_valid_nxt  = r_buf_valid;
        w_halt_nxt       = r_halt;

        if (redirect_valid) begin
            w_pc_nxt        = redirect_pc;
            w_buf_valid_nxt = 1'b0;
            w_halt_nxt      = 1'b0;
            case (r_state)
                ST_FETCH: begin
                    if (w_req && !imem_ready) begin
                        w_drain_addr_nxt = r_pc;
                        w_state_nxt      = ST_DRAIN;
                    end
                end
                // Keep draining; leave only if the old request completes this cycle.
                ST_DRAIN: begin
                    if (imem_ready) begin
                        w_state_nxt = ST_FETCH;
                    end
                end
                default: w_state_nxt = ST_FETCH;
            endcase
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (w_consume) begin
                        w_buf_valid_nxt = 1'b0;
                        if (w_is_halt) begin
                            w_state_nxt = ST_HALTED;
                            w_halt_nxt  = 1'b1;
                        end else begin
                            w_pc_nxt = w_pc_inc;
                        end
                    end else if (w_avail && !r_buf_valid) begin
                        w_buf_inst_nxt  = imem_rdata;
                        w_buf_valid_nxt = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (imem_ready) begin
                        w_state_nxt = ST_FETCH;
                    end
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_FETCH;
            r_pc         <= RESET_PC;
            r_drain_addr <= 16'h0000;
            r_buf_inst   <= 16'h0000;
            r_buf_valid  <= 1'b0;
            r_halt       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_drain_addr <= w_drain_addr_nxt;
            r_buf_inst   <= w_buf_inst_nxt;
            r_buf_valid  <= w_buf_valid_nxt;
            r_halt       <= w_halt_nxt;
        end
    end

endmodule
